uart_echo_fifo: RTL and testbench

- Byte buffer between uart_rx_deserialise (upstream) and uart_tx_serialise (downstream) in the echo path.
- Captures every byte the receiver flags valid and queues it.
- Drains the queue into the transmitter with a send/ready handshake, so back-to-back received bytes are not lost while the transmitter is busy.
- Also exposes occupancy and a sticky overflow flag for LED/status use.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/uart_echo_fifo.sv | 92 +++++++++
 tb/tb_uart_echo_fifo.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, ASCII digit codes and the echo-buffer handshake state encoding.
package uart_pkg;

    localparam int CLK_RATE = 12000000;
    localparam int BAUD     = 115200;
    localparam int DATA_W   = 8;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_1 = 8'h31;
    localparam logic [7:0] ASCII_2 = 8'h32;
    localparam logic [7:0] ASCII_3 = 8'h33;
    localparam logic [7:0] ASCII_4 = 8'h34;
    localparam logic [7:0] ASCII_5 = 8'h35;
    localparam logic [7:0] ASCII_6 = 8'h36;
    localparam logic [7:0] ASCII_7 = 8'h37;
    localparam logic [7:0] ASCII_8 = 8'h38;
    localparam logic [7:0] ASCII_9 = 8'h39;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } echo_state_t;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_0 + {4'd0, d};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: synchronous-write register storage, wrapping pointers,
// registered count with empty/full derived from the next count.
module sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W:0]   count_nxt;

    // A write is judged against the current full flag, so a pop in the same
    // cycle does not make room for it.
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    always_comb begin
        count_nxt = count;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_echo_fifo.sv
// Echo-path byte buffer: queues received bytes and feeds them to the serialiser
// through a send/ready handshake; reports occupancy and sticky overflow.
module uart_echo_fifo #(
    parameter  int DATA_W = uart_pkg::DATA_W,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_byte,
    input  logic              tx_ready,
    output logic              tx_send,
    output logic [DATA_W-1:0] tx_byte,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    input  logic              clr_overflow
);

    import uart_pkg::*;

    echo_state_t       state;
    echo_state_t       state_nxt;
    logic              pop;
    logic              wb_cnt;
    logic              wb_cnt_nxt;
    logic [DATA_W-1:0] fifo_dout;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_valid),
        .pop   (pop),
        .din   (rx_byte),
        .dout  (fifo_dout),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        wb_cnt_nxt = wb_cnt;
        case (state)
            IDLE: begin
                wb_cnt_nxt = 1'b0;
                if (!empty && tx_ready) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                wb_cnt_nxt = 1'b0;
                state_nxt  = WAIT_BUSY;
            end
            // Give up waiting for busy after two cycles: an instant serialiser
            // may accept and finish without ever dropping ready.
            WAIT_BUSY: begin
                if (!tx_ready || wb_cnt) state_nxt = WAIT_DONE;
                else                     wb_cnt_nxt = 1'b1;
            end
            WAIT_DONE: begin
                if (tx_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wb_cnt   <= 1'b0;
            tx_send  <= 1'b0;
            tx_byte  <= '0;
            overflow <= 1'b0;
        end else begin
            state   <= state_nxt;
            wb_cnt  <= wb_cnt_nxt;
            tx_send <= pop;
            if (pop) tx_byte <= fifo_dout;
            if (rx_valid && full) overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed self-checking bench for uart_echo_fifo with a simple serialiser model.
module tb_uart_echo_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       tx_ready;
    logic       tx_send;
    logic [7:0] tx_byte;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       clr_overflow;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_echo_fifo #(
        .DATA_W (8),
        .DEPTH  (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .tx_ready     (tx_ready),
        .tx_send      (tx_send),
        .tx_byte      (tx_byte),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input logic clr);
        rx_valid     = 1'b1;
        rx_byte      = b;
        clr_overflow = clr;
        @(negedge clk);
        rx_valid     = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic wait_send(input logic [7:0] exp, output int at);
        int n = 0;
        @(negedge clk);
        while (tx_send !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_seen", 32'(tx_send), 32'd1);
        chk("tx_byte", 32'(tx_byte), 32'(exp));
        at = cyc;
    endtask

    // Serialiser busy for 100 cycles starting the cycle after tx_send.
    task automatic finish_frame();
        int extra = 0;
        tx_ready = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx_send === 1'b1) extra++;
        end
        tx_ready = 1'b1;
        chk("one_send_per_frame", 32'(extra), 32'd0);
    endtask

    task automatic serve(input logic [7:0] exp);
        int at;
        wait_send(exp, at);
        finish_frame();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        int prev;
        int sends;

        rst_n        = 1'b0;
        rx_valid     = 1'b0;
        rx_byte      = 8'h00;
        tx_ready     = 1'b1;
        clr_overflow = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_tx_send", 32'(tx_send), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte latency
        rx_valid = 1'b1;
        rx_byte  = 8'h41;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("single_count1", 32'(count), 32'd1);
        chk("single_empty0", 32'(empty), 32'd0);
        chk("single_no_send_early", 32'(tx_send), 32'd0);
        @(negedge clk);
        chk("single_send", 32'(tx_send), 32'd1);
        chk("single_byte", 32'(tx_byte), 32'h41);
        chk("single_count0", 32'(count), 32'd0);
        chk("single_empty1", 32'(empty), 32'd1);
        @(negedge clk);
        chk("single_send_1cyc", 32'(tx_send), 32'd0);
        repeat (10) @(negedge clk);

        // Burst while serialiser busy
        tx_ready = 1'b0;
        sends = 0;
        for (int unsigned i = 0; i < 5; i++) begin
            write_byte(8'(8'h30 + i), 1'b0);
            if (tx_send === 1'b1) sends++;
        end
        repeat (3) begin
            @(negedge clk);
            if (tx_send === 1'b1) sends++;
        end
        chk("burst_count", 32'(count), 32'd5);
        chk("burst_no_send", 32'(sends), 32'd0);
        tx_ready = 1'b1;
        for (int unsigned i = 0; i < 5; i++) serve(8'(8'h30 + i));
        chk("burst_empty", 32'(empty), 32'd1);

        // Fill, overflow with simultaneous clear (set wins), drain, clear
        tx_ready = 1'b0;
        for (int unsigned i = 0; i < 16; i++) write_byte(8'(i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_no_ovf", 32'(overflow), 32'd0);
        write_byte(8'h10, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_full", 32'(full), 32'd1);
        tx_ready = 1'b1;
        for (int unsigned i = 0; i < 16; i++) serve(8'(i));
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Simultaneous push and pop at count 3
        tx_ready = 1'b0;
        write_byte(8'hA0, 1'b0);
        write_byte(8'hA1, 1'b0);
        write_byte(8'hA2, 1'b0);
        chk("pp_count_pre", 32'(count), 32'd3);
        rx_valid = 1'b1;
        rx_byte  = 8'hA3;
        tx_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("pp_count_same", 32'(count), 32'd3);
        chk("pp_send", 32'(tx_send), 32'd1);
        chk("pp_byte", 32'(tx_byte), 32'hA0);
        finish_frame();
        serve(8'hA1);
        serve(8'hA2);
        serve(8'hA3);
        chk("pp_empty", 32'(empty), 32'd1);

        // Pointer wrap with an instant serialiser: 40 bytes in batches of 8
        for (int unsigned b = 0; b < 5; b++) begin
            tx_ready = 1'b0;
            for (int unsigned j = 0; j < 8; j++) write_byte(8'(8'h80 + 8 * b + j), 1'b0);
            tx_ready = 1'b1;
            prev = 0;
            for (int unsigned j = 0; j < 8; j++) begin
                wait_send(8'(8'h80 + 8 * b + j), at);
                if (j > 0) chk("instant_spacing", 32'(at - prev), 32'd5);
                prev = at;
            end
        end
        repeat (10) @(negedge clk);
        chk("wrap_empty", 32'(empty), 32'd1);

        // Asynchronous reset while in WAIT_DONE with four bytes queued
        tx_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++) write_byte(8'(8'hC0 + i), 1'b0);
        tx_ready = 1'b1;
        wait_send(8'hC0, at);
        tx_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_count4", 32'(count), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_send", 32'(tx_send), 32'd0);
        chk("mid_rst_byte", 32'(tx_byte), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        tx_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        sends = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_send === 1'b1) sends++;
        end
        chk("post_rst_no_send", 32'(sends), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
